// File: rtl/counter_datapath_unit.sv
// Prescaled 0..MAX_COUNT up/down counter with cascaded BCD digits for the FND path.
// Optional build macro COUNTER_SAT_EN: saturate at the ends instead of wrapping.
module counter_datapath_unit #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic        mode,
    output logic [13:0] count,
    output logic [15:0] bcd,
    output logic        tick,
    output logic        wrap
);

    localparam int              PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [13:0]     CNT_MAX  = 14'(MAX_COUNT);

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] res;
        int          r;
        r   = v;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    localparam logic [15:0] BCD_MAX = to_bcd(MAX_COUNT);

    // Decade cascade: a digit only moves when every lower digit rolled over.
    function automatic logic [15:0] bcd_inc(input logic [15:0] b);
        logic [15:0] res;
        logic        cy;
        res = b;
        cy  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cy) begin
                if (res[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
                    cy = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] b);
        logic [15:0] res;
        logic        bw;
        res = b;
        bw  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bw) begin
                if (res[i*4 +: 4] == 4'd0) begin
                    res[i*4 +: 4] = 4'd9;
                end else begin
                    res[i*4 +: 4] = res[i*4 +: 4] - 4'd1;
                    bw = 1'b0;
                end
            end
        end
        return res;
    endfunction

    logic [PW-1:0] ps_q, ps_d;
    logic [13:0]   count_q, count_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;

    always_comb begin
        ps_d    = ps_q;
        count_d = count_q;
        bcd_d   = bcd_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear) begin
            ps_d    = '0;
            count_d = '0;
            bcd_d   = '0;
        end else if (enable) begin
            if (ps_q == PS_LAST) begin
                ps_d   = '0;
                tick_d = 1'b1;
                if (!mode) begin
                    if (count_q == CNT_MAX) begin
`ifdef COUNTER_SAT_EN
                        count_d = count_q;
                        bcd_d   = bcd_q;
`else
                        count_d = '0;
                        bcd_d   = '0;
                        wrap_d  = 1'b1;
`endif
                    end else begin
                        count_d = count_q + 14'd1;
                        bcd_d   = bcd_inc(bcd_q);
                    end
                end else begin
                    if (count_q == '0) begin
`ifdef COUNTER_SAT_EN
                        count_d = count_q;
                        bcd_d   = bcd_q;
`else
                        count_d = CNT_MAX;
                        bcd_d   = BCD_MAX;
                        wrap_d  = 1'b1;
`endif
                    end else begin
                        count_d = count_q - 14'd1;
                        bcd_d   = bcd_dec(bcd_q);
                    end
                end
            end else begin
                ps_d = ps_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q    <= '0;
            count_q <= '0;
            bcd_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            count_q <= count_d;
            bcd_q   <= bcd_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign bcd   = bcd_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_counter_datapath_unit.sv
// Directed bench for counter_datapath_unit with TICK_DIV=4; honours COUNTER_SAT_EN.
module tb_counter_datapath_unit;

    logic        clk = 1'b0;
    logic        rst, enable, clear, mode;
    logic [13:0] count;
    logic [15:0] bcd;
    logic        tick, wrap;

    int errs = 0;
    int nchk = 0;
    int ticks;

    counter_datapath_unit #(.TICK_DIV(4), .MAX_COUNT(9999)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .mode(mode),
        .count(count), .bcd(bcd), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; clear = 1'b0; mode = 1'b0;
        run(2);
        check("rst_count", 32'(count), 0);
        check("rst_bcd",   32'(bcd),   0);
        check("rst_tick",  32'(tick),  0);
        check("rst_wrap",  32'(wrap),  0);

        // run up, 12 edges
        rst = 1'b1; enable = 1'b1;
        ticks = 0;
        for (int e = 1; e <= 12; e++) begin
            run(1);
            ticks += int'(tick);
            if (e == 3)  check("up_e3",  32'(count), 0);
            if (e == 4)  check("up_e4",  32'(count), 1);
            if (e == 8)  check("up_e8",  32'(count), 2);
            if (e == 12) check("up_e12", 32'(count), 3);
        end
        check("up_ticks", 32'(ticks), 3);
        check("up_bcd",   32'(bcd),   32'h0003);

        // down from 0
        clear = 1'b1; run(1); clear = 1'b0;
        check("clr_count", 32'(count), 0);
        mode = 1'b1;
        run(3);
        check("dn_pre", 32'(count), 0);
        run(1);
        check("dn_tick", 32'(tick), 1);
`ifdef COUNTER_SAT_EN
        check("dn_count", 32'(count), 0);
        check("dn_bcd",   32'(bcd),   32'h0000);
        check("dn_wrap",  32'(wrap),  0);
`else
        check("dn_count", 32'(count), 9999);
        check("dn_bcd",   32'(bcd),   32'h9999);
        check("dn_wrap",  32'(wrap),  1);
`endif
        run(1);
        check("dn_wrap_1cyc", 32'(wrap), 0);
        check("dn_tick_1cyc", 32'(tick), 0);

        // up to 0999, carry into thousands, then up to 9999 and wrap
        clear = 1'b1; run(1); clear = 1'b0; mode = 1'b0;
        run(999 * 4);
        check("c999_count", 32'(count), 999);
        check("c999_bcd",   32'(bcd),   32'h0999);
        run(4);
        check("c1000_count", 32'(count), 1000);
        check("c1000_bcd",   32'(bcd),   32'h1000);
        run(8999 * 4);
        check("c9999_count", 32'(count), 9999);
        check("c9999_bcd",   32'(bcd),   32'h9999);
        check("c9999_wrap",  32'(wrap),  0);
        run(4);
        check("upw_tick", 32'(tick), 1);
`ifdef COUNTER_SAT_EN
        check("upw_count", 32'(count), 9999);
        check("upw_bcd",   32'(bcd),   32'h9999);
        check("upw_wrap",  32'(wrap),  0);
`else
        check("upw_count", 32'(count), 0);
        check("upw_bcd",   32'(bcd),   32'h0000);
        check("upw_wrap",  32'(wrap),  1);
`endif

        // clear on a step edge
        clear = 1'b1; run(1); clear = 1'b0;
        run(4);
        check("cs_pre", 32'(count), 1);
        run(3);
        clear = 1'b1; run(1);
        check("cs_count", 32'(count), 0);
        check("cs_tick",  32'(tick),  0);
        clear = 1'b0;
        run(3);
        check("cs_rel3", 32'(count), 0);
        run(1);
        check("cs_rel4", 32'(count), 1);
        check("cs_rel4_tick", 32'(tick), 1);

        // pause / resume with prescaler at 2
        run(2);
        enable = 1'b0;
        run(10);
        check("pz_hold", 32'(count), 1);
        check("pz_tick", 32'(tick),  0);
        enable = 1'b1;
        run(1);
        check("pz_res1", 32'(count), 1);
        run(1);
        check("pz_res2", 32'(count), 2);
        check("pz_res2_tick", 32'(tick), 1);

        // async reset mid-operation at count 5
        run(12);
        check("ar_pre", 32'(count), 5);
        check("ar_pre_tick", 32'(tick), 1);
        #3 rst = 1'b0;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_bcd",   32'(bcd),   0);
        check("ar_tick",  32'(tick),  0);
        check("ar_wrap",  32'(wrap),  0);
        #1 rst = 1'b1;
        run(3);
        check("ar_rel3", 32'(count), 0);
        run(1);
        check("ar_rel4", 32'(count), 1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
